// File: rtl/obi_pkg.sv
// OBI bus configuration and channel types shared by the scratch memory and its initiators.
// Address and data are fixed at 32 bits; the ID width is set once here.
package obi_pkg;

  localparam int unsigned ObiIdWidth = 4;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    AddrWidth: 32,
    DataWidth: 32,
    IdWidth:   ObiIdWidth
  };

  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [ObiIdWidth-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0]           rdata;
    logic [ObiIdWidth-1:0] rid;
    logic                  err;
    logic                  r_optional;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/obi_scratch_mem.sv
// OBI subordinate scratch memory: NumWords x 32-bit with byte enables, optional grant stalls,
// one-cycle response latency, error responses for bad addresses and saturating access counters.
module obi_scratch_mem #(
  parameter obi_pkg::obi_cfg_t ObiCfg     = obi_pkg::ObiDefaultConfig,
  parameter int unsigned       NumWords   = 256,
  parameter logic [31:0]       BaseAddr   = 32'h1A10_0000,
  parameter int unsigned       WaitCycles = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  obi_pkg::obi_req_t sbr_obi_req_i,
  output obi_pkg::obi_rsp_t sbr_obi_rsp_o,
  output logic [15:0]       num_reads_o,
  output logic [15:0]       num_writes_o
);

  localparam int          IdxW    = $clog2(NumWords);
  localparam int          IdW     = ObiCfg.IdWidth;
  localparam logic [3:0]  WaitCnt = 4'(WaitCycles);
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * NumWords);

  typedef enum logic {IDLE, STALL} state_e;

  state_e          r_state;
  logic [3:0]      r_cnt;
  logic [31:0]     r_mem [NumWords];

  logic            r_vld_p1;
  logic [31:0]     r_rdata_p1;
  logic [IdW-1:0]  r_rid_p1;
  logic            r_err_p1;
  logic [15:0]     r_num_reads;
  logic [15:0]     r_num_writes;

  logic            w_gnt;
  logic            w_accept;
  logic            w_in_range;
  logic            w_aligned;
  logic            w_ok;
  logic [IdxW-1:0] w_idx;

  assign w_in_range = (sbr_obi_req_i.a.addr >= BaseAddr) &&
                      ({1'b0, sbr_obi_req_i.a.addr} < EndAddr);
  assign w_aligned  = (sbr_obi_req_i.a.addr[1:0] == 2'b00);
  assign w_ok       = w_in_range && w_aligned;
  assign w_idx      = IdxW'((sbr_obi_req_i.a.addr - BaseAddr) >> 2);
  assign w_accept   = sbr_obi_req_i.req && w_gnt;

  // Grant is combinational; with stalls it only rises once the counter reaches WaitCycles.
  always_comb begin
    w_gnt = 1'b0;
    if (!rst_i && sbr_obi_req_i.req) begin
      if (WaitCycles == 0) w_gnt = 1'b1;
      else                 w_gnt = (r_state == STALL) && (r_cnt == WaitCnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sbr_obi_req_i.req && (WaitCycles != 0)) begin
            r_state <= STALL;
            r_cnt   <= 4'd1;
          end
        end
        STALL: begin
          if (!sbr_obi_req_i.req || (r_cnt == WaitCnt)) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; only enabled bytes of good writes are touched.
  always_ff @(posedge clk_i) begin
    if (w_accept && w_ok && sbr_obi_req_i.a.we) begin
      for (int b = 0; b < 4; b++) begin
        if (sbr_obi_req_i.a.be[b]) r_mem[w_idx][8*b +: 8] <= sbr_obi_req_i.a.wdata[8*b +: 8];
      end
    end
  end

  // ---- stage p1: response registered one cycle after acceptance ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1   <= 1'b0;
      r_rdata_p1 <= 32'd0;
      r_rid_p1   <= '0;
      r_err_p1   <= 1'b0;
    end else begin
      r_vld_p1   <= w_accept;
      r_rdata_p1 <= 32'd0;
      r_rid_p1   <= '0;
      r_err_p1   <= 1'b0;
      if (w_accept) begin
        r_rid_p1 <= sbr_obi_req_i.a.aid[IdW-1:0];
        r_err_p1 <= !w_ok;
        if (w_ok && !sbr_obi_req_i.a.we) r_rdata_p1 <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_num_reads  <= 16'd0;
      r_num_writes <= 16'd0;
    end else if (w_accept) begin
      if (sbr_obi_req_i.a.we) begin
        if (r_num_writes != 16'hFFFF) r_num_writes <= r_num_writes + 16'd1;
      end else begin
        if (r_num_reads != 16'hFFFF) r_num_reads <= r_num_reads + 16'd1;
      end
    end
  end

  always_comb begin
    sbr_obi_rsp_o         = '0;
    sbr_obi_rsp_o.gnt     = w_gnt;
    sbr_obi_rsp_o.rvalid  = r_vld_p1;
    sbr_obi_rsp_o.r.rdata = r_rdata_p1;
    sbr_obi_rsp_o.r.rid   = r_rid_p1;
    sbr_obi_rsp_o.r.err   = r_err_p1;
  end

  assign num_reads_o  = r_num_reads;
  assign num_writes_o = r_num_writes;

endmodule

// File: tb/tb_obi_scratch_mem.sv
// Directed bench for obi_scratch_mem: one zero-wait instance and one three-wait-cycle instance.
module tb_obi_scratch_mem;
  import obi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  obi_req_t    req0, req3;
  obi_rsp_t    rsp0, rsp3;
  logic [15:0] nrd0, nwr0, nrd3, nwr3;

  int n_checks = 0;
  int n_fail   = 0;

  logic        g_gnt, g_rvalid, g_err;
  logic [31:0] g_rdata;
  logic [3:0]  g_rid;

  obi_scratch_mem #(.WaitCycles(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .sbr_obi_req_i(req0), .sbr_obi_rsp_o(rsp0),
    .num_reads_o(nrd0), .num_writes_o(nwr0));

  obi_scratch_mem #(.WaitCycles(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .sbr_obi_req_i(req3), .sbr_obi_rsp_o(rsp3),
    .num_reads_o(nrd3), .num_writes_o(nwr3));

  task automatic mk_req(output obi_req_t r, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid);
    r         = '0;
    r.req     = 1'b1;
    r.a.we    = we;
    r.a.addr  = addr;
    r.a.be    = be;
    r.a.wdata = wdata;
    r.a.aid   = aid;
  endtask

  // One single-cycle request on the zero-wait instance; records gnt and the following response.
  task automatic do_xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [3:0] aid);
    obi_req_t r;
    @(posedge clk); #1;
    mk_req(r, we, addr, be, wdata, aid);
    req0 = r;
    @(negedge clk);
    g_gnt = rsp0.gnt;
    @(posedge clk); #1;
    req0 = '0;
    @(negedge clk);
    g_rvalid = rsp0.rvalid;
    g_rdata  = rsp0.r.rdata;
    g_rid    = rsp0.r.rid;
    g_err    = rsp0.r.err;
  endtask

  task automatic test_reset;
    obi_req_t r;
    rst = 1'b1;
    mk_req(r, 1'b1, 32'h1A10_0000, 4'hF, 32'h1234_5678, 4'd1);
    req0 = r;
    req3 = r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp0.gnt !== 1'b0 || rsp3.gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt: got %0b/%0b want 0/0", rsp0.gnt, rsp3.gnt);
    end
    n_checks++;
    if (rsp0 !== '0 || rsp3 !== '0) begin
      n_fail++; $display("FAIL rst_rsp: got %h/%h want 0/0", rsp0, rsp3);
    end
    n_checks++;
    if (nrd0 !== 16'd0 || nwr0 !== 16'd0 || nrd3 !== 16'd0 || nwr3 !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt: got %0d %0d %0d %0d want 0", nrd0, nwr0, nrd3, nwr3);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    req0 = '0;
    req3 = '0;
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b0 || nwr0 !== 16'd0) begin
      n_fail++; $display("FAIL rst_drop: got rvalid=%0b nwr=%0d want 0/0", rsp0.rvalid, nwr0);
    end
  endtask

  task automatic test_basic;
    do_xact(1'b1, 32'h1A10_0010, 4'hF, 32'hDEAD_BEEF, 4'd3);
    n_checks++;
    if (g_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %0b want 1", g_gnt); end
    n_checks++;
    if (g_rvalid !== 1'b1 || g_rid !== 4'd3 || g_rdata !== 32'd0 || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp: got v=%0b rid=%0d rdata=%h err=%0b want 1 3 0 0", g_rvalid, g_rid, g_rdata, g_err);
    end
    do_xact(1'b0, 32'h1A10_0010, 4'hF, 32'h0, 4'd5);
    n_checks++;
    if (g_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %0b want 1", g_gnt); end
    n_checks++;
    if (g_rvalid !== 1'b1 || g_rid !== 4'd5 || g_rdata !== 32'hDEAD_BEEF || g_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rsp: got v=%0b rid=%0d rdata=%h err=%0b want 1 5 deadbeef 0", g_rvalid, g_rid, g_rdata, g_err);
    end
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b0 || rsp0.r.rdata !== 32'd0 || rsp0.r.rid !== 4'd0) begin
      n_fail++;
      $display("FAIL rsp_idle: got v=%0b rdata=%h rid=%0d want 0 0 0", rsp0.rvalid, rsp0.r.rdata, rsp0.r.rid);
    end
  endtask

  task automatic test_byte_enable;
    do_xact(1'b1, 32'h1A10_0000, 4'hF, 32'h1122_3344, 4'd0);
    do_xact(1'b1, 32'h1A10_0000, 4'b0101, 32'hAABB_CCDD, 4'd0);
    do_xact(1'b0, 32'h1A10_0000, 4'hF, 32'h0, 4'd7);
    n_checks++;
    if (g_rdata !== 32'h11BB_33DD || g_rid !== 4'd7) begin
      n_fail++; $display("FAIL byte_en: got %h rid=%0d want 11bb33dd rid=7", g_rdata, g_rid);
    end
  endtask

  task automatic test_errors;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_xact(1'b0, 32'h1A10_0400, 4'hF, 32'h0, 4'd1);
    n_checks++;
    if (g_gnt !== 1'b1 || g_rvalid !== 1'b1 || g_err !== 1'b1 || g_rdata !== 32'd0) begin
      n_fail++; $display("FAIL err_range: got gnt=%0b v=%0b err=%0b rdata=%h want 1 1 1 0", g_gnt, g_rvalid, g_err, g_rdata);
    end
    do_xact(1'b1, 32'h1A10_0002, 4'hF, 32'hFFFF_FFFF, 4'd2);
    n_checks++;
    if (g_rvalid !== 1'b1 || g_err !== 1'b1 || g_rdata !== 32'd0 || g_rid !== 4'd2) begin
      n_fail++; $display("FAIL err_align: got v=%0b err=%0b rdata=%h rid=%0d want 1 1 0 2", g_rvalid, g_err, g_rdata, g_rid);
    end
    n_checks++;
    if (nrd0 !== 16'd1 || nwr0 !== 16'd1) begin
      n_fail++; $display("FAIL err_cnt: got rd=%0d wr=%0d want 1/1", nrd0, nwr0);
    end
    do_xact(1'b0, 32'h1A10_0000, 4'hF, 32'h0, 4'd3);
    n_checks++;
    if (g_err !== 1'b0 || g_rdata !== 32'h11BB_33DD) begin
      n_fail++; $display("FAIL err_nomod: got err=%0b rdata=%h want 0 11bb33dd", g_err, g_rdata);
    end
    do_xact(1'b0, 32'h1A0F_FFFC, 4'hF, 32'h0, 4'd4);
    n_checks++;
    if (g_err !== 1'b1 || g_rdata !== 32'd0) begin
      n_fail++; $display("FAIL err_below: got err=%0b rdata=%h want 1 0", g_err, g_rdata);
    end
    do_xact(1'b1, 32'h1A10_03FC, 4'hF, 32'hCAFE_F00D, 4'd5);
    do_xact(1'b0, 32'h1A10_03FC, 4'hF, 32'h0, 4'd6);
    n_checks++;
    if (g_err !== 1'b0 || g_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL last_word: got err=%0b rdata=%h want 0 cafef00d", g_err, g_rdata);
    end
  endtask

  task automatic test_back_to_back;
    obi_req_t r;
    @(posedge clk); #1;
    mk_req(r, 1'b1, 32'h1A10_001C, 4'hF, 32'h0000_00AA, 4'd1);
    req0 = r;
    @(negedge clk);
    n_checks++;
    if (rsp0.gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %0b want 1", rsp0.gnt); end
    @(posedge clk); #1;
    mk_req(r, 1'b0, 32'h1A10_001C, 4'hF, 32'h0, 4'd2);
    req0 = r;
    @(negedge clk);
    n_checks++;
    if (rsp0.gnt !== 1'b1 || rsp0.rvalid !== 1'b1 || rsp0.r.rid !== 4'd1 || rsp0.r.rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_wr: got gnt=%0b v=%0b rid=%0d rdata=%h want 1 1 1 0", rsp0.gnt, rsp0.rvalid, rsp0.r.rid, rsp0.r.rdata);
    end
    @(posedge clk); #1;
    req0 = '0;
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b1 || rsp0.r.rid !== 4'd2 || rsp0.r.rdata !== 32'h0000_00AA) begin
      n_fail++; $display("FAIL b2b_rd: got v=%0b rid=%0d rdata=%h want 1 2 000000aa", rsp0.rvalid, rsp0.r.rid, rsp0.r.rdata);
    end
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got rvalid=%0b want 0", rsp0.rvalid); end
  endtask

  task automatic test_wait;
    obi_req_t r;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      if (t == 0) mk_req(r, 1'b1, 32'h1A10_001C, 4'hF, 32'h5A5A_1234, 4'd6);
      else        mk_req(r, 1'b0, 32'h1A10_001C, 4'hF, 32'h0, 4'(8 + t));
      req3 = r;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        n_checks++;
        if (rsp3.gnt !== (c == 4) || rsp3.rvalid !== 1'b0) begin
          n_fail++; $display("FAIL wait_gnt t%0d c%0d: got gnt=%0b v=%0b want %0b 0", t, c, rsp3.gnt, rsp3.rvalid, (c == 4));
        end
      end
      @(posedge clk); #1;
      req3 = '0;
      @(negedge clk);
      n_checks++;
      if (rsp3.rvalid !== 1'b1 || rsp3.r.rid !== r.a.aid ||
          rsp3.r.rdata !== ((t == 0) ? 32'd0 : 32'h5A5A_1234)) begin
        n_fail++; $display("FAIL wait_rsp t%0d: got v=%0b rid=%0d rdata=%h", t, rsp3.rvalid, rsp3.r.rid, rsp3.r.rdata);
      end
      if (t == 1) begin
        @(posedge clk); #1;
        mk_req(r, 1'b0, 32'h1A10_001C, 4'hF, 32'h0, 4'd15);
        req3 = r;
        repeat (2) begin
          @(negedge clk);
          n_checks++;
          if (rsp3.gnt !== 1'b0) begin n_fail++; $display("FAIL drop_gnt: got %0b want 0", rsp3.gnt); end
        end
        @(posedge clk); #1;
        req3 = '0;
        repeat (3) begin
          @(negedge clk);
          n_checks++;
          if (rsp3.gnt !== 1'b0 || rsp3.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle: got gnt=%0b v=%0b want 0 0", rsp3.gnt, rsp3.rvalid);
          end
        end
        n_checks++;
        if (nrd3 !== 16'd1 || nwr3 !== 16'd1) begin
          n_fail++; $display("FAIL drop_cnt: got rd=%0d wr=%0d want 1/1", nrd3, nwr3);
        end
      end
    end
  endtask

  task automatic test_reset_drop;
    obi_req_t r;
    @(posedge clk); #1;
    mk_req(r, 1'b0, 32'h1A10_001C, 4'hF, 32'h0, 4'd4);
    req0 = r;
    @(negedge clk);
    n_checks++;
    if (rsp0.gnt !== 1'b1) begin n_fail++; $display("FAIL rdrop_gnt: got %0b want 1", rsp0.gnt); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (rsp0.gnt !== 1'b0) begin n_fail++; $display("FAIL rdrop_gnt_rst: got %0b want 0", rsp0.gnt); end
    @(posedge clk); #1;
    req0 = '0;
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b0 || nrd0 !== 16'd0 || nwr0 !== 16'd0) begin
      n_fail++; $display("FAIL rdrop_rsp: got v=%0b rd=%0d wr=%0d want 0 0 0", rsp0.rvalid, nrd0, nwr0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp0.rvalid !== 1'b0) begin n_fail++; $display("FAIL rdrop_late: got rvalid=%0b want 0", rsp0.rvalid); end
    do_xact(1'b0, 32'h1A10_001C, 4'hF, 32'h0, 4'd9);
    n_checks++;
    if (g_rdata !== 32'h0000_00AA || g_err !== 1'b0 || nrd0 !== 16'd1) begin
      n_fail++; $display("FAIL rdrop_keep: got rdata=%h err=%0b rd=%0d want 000000aa 0 1", g_rdata, g_err, nrd0);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req0 = '0;
    req3 = '0;
    test_reset();
    test_basic();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_wait();
    test_reset_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
